// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher nibble receiver: frame geometry, counter
// width and the receive FSM state encoding.
package cipher_pkg;

  localparam int unsigned DATA_BITS = 4;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/cipher_nibble_rx.sv
// Serial receiver for encrypted nibbles: start, P, Q, R, S, optional even
// parity, stop. A good frame is presented as pqrs with a valid/ready
// handshake; parity, stop-bit and overrun faults raise sticky flags.
module cipher_nibble_rx
  import cipher_pkg::*;
#(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_tick,
  input  logic             ser_in,
  output logic [3:0]       pqrs,
  output logic             pqrs_valid,
  input  logic             pqrs_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  input  logic             err_clr,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_next;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;

  logic                 start_seen;
  logic                 data_tick;
  logic                 parity_tick;
  logic                 frame_done;
  logic                 good_frame;
  logic                 load;
  logic                 set_perr;
  logic                 set_ferr;
  logic                 set_ovr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; every transition is gated by bit_tick
  always_comb begin
    state_next = state;
    if (bit_tick) begin
      unique case (state)
        ST_IDLE:   if (!ser_in) state_next = ST_DATA;
        ST_DATA:   if (bit_idx == LAST_IDX) state_next = PARITY_EN ? ST_PARITY : ST_STOP;
        ST_PARITY: state_next = ST_STOP;
        ST_STOP:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Per-state strobes and end-of-frame decisions
  always_comb begin
    start_seen  = bit_tick && (state == ST_IDLE) && !ser_in;
    data_tick   = bit_tick && (state == ST_DATA);
    parity_tick = bit_tick && (state == ST_PARITY);
    frame_done  = bit_tick && (state == ST_STOP);
    good_frame  = frame_done && ser_in && !par_bad;
    set_ferr    = frame_done && !ser_in;
    set_perr    = frame_done && par_bad;
    load        = good_frame && (!pqrs_valid || pqrs_ready);
    set_ovr     = good_frame && pqrs_valid && !pqrs_ready;
  end

  // Bit index, MSB-first shift register and parity mismatch capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      if (start_seen) begin
        bit_idx <= '0;
        par_bad <= 1'b0;
      end else if (data_tick) begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= {shreg[DATA_BITS-2:0], ser_in};
      end else if (parity_tick) begin
        par_bad <= ^{shreg, ser_in};
      end
    end
  end

  // Holding register with valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pqrs       <= '0;
      pqrs_valid <= 1'b0;
    end else if (load) begin
      pqrs       <= shreg;
      pqrs_valid <= 1'b1;
    end else if (pqrs_valid && pqrs_ready) begin
      pqrs_valid <= 1'b0;
    end
  end

  // Saturating count of delivered nibbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      frame_cnt <= '0;
    else if (load && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
  end

  // Sticky error flags; a new set wins over err_clr in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (set_perr)     parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (set_ferr)     frame_err  <= 1'b1;
      else if (err_clr) frame_err  <= 1'b0;
      if (set_ovr)      overrun    <= 1'b1;
      else if (err_clr) overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cipher_nibble_rx.sv
// Self-checking bench for cipher_nibble_rx: directed frames followed by
// randomized traffic, compared every cycle against a frame-level model.
module tb_cipher_nibble_rx;

  localparam bit PAR_EN = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_tick;
  logic       ser_in;
  logic [3:0] pqrs;
  logic       pqrs_valid;
  logic       pqrs_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic [7:0] frame_cnt;

  cipher_nibble_rx #(.PARITY_EN(PAR_EN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_tick   (bit_tick),
    .ser_in     (ser_in),
    .pqrs       (pqrs),
    .pqrs_valid (pqrs_valid),
    .pqrs_ready (pqrs_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Frame-level reference state
  logic [3:0] m_pqrs;
  logic       m_valid;
  logic       m_perr;
  logic       m_ferr;
  logic       m_ovr;
  int         m_cnt;
  bit         rnd_ctl = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pqrs  = 4'b0000;
    m_valid = 1'b0;
    m_perr  = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic check_all(input string where);
    chk({where, ".pqrs"},       {4'b0, pqrs},       {4'b0, m_pqrs});
    chk({where, ".pqrs_valid"}, {7'b0, pqrs_valid}, {7'b0, m_valid});
    chk({where, ".parity_err"}, {7'b0, parity_err}, {7'b0, m_perr});
    chk({where, ".frame_err"},  {7'b0, frame_err},  {7'b0, m_ferr});
    chk({where, ".overrun"},    {7'b0, overrun},    {7'b0, m_ovr});
    chk({where, ".frame_cnt"},  frame_cnt,          8'(m_cnt));
  endtask

  // One clock: update the model for the coming rising edge, then sample.
  task automatic step(input bit is_stop, input bit good, input bit perr_set,
                      input bit ferr_set, input logic [3:0] nib);
    bit ovr_set;
    ovr_set = 1'b0;
    if (rnd_ctl) begin
      pqrs_ready = ($urandom_range(0, 2) != 0);
      err_clr    = ($urandom_range(0, 15) == 0);
    end
    if (is_stop && good) begin
      if (!m_valid || pqrs_ready) begin
        m_valid = 1'b1;
        m_pqrs  = nib;
        if (m_cnt < 255) m_cnt++;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (m_valid && pqrs_ready) begin
      m_valid = 1'b0;
    end
    m_perr = perr_set ? 1'b1 : (err_clr ? 1'b0 : m_perr);
    m_ferr = ferr_set ? 1'b1 : (err_clr ? 1'b0 : m_ferr);
    m_ovr  = ovr_set  ? 1'b1 : (err_clr ? 1'b0 : m_ovr);
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  // One non-final serial bit: tick cycle plus three quiet cycles
  task automatic send_bit(input logic b);
    ser_in   = b;
    bit_tick = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    bit_tick = 1'b0;
    ser_in   = 1'b1;
    idle_steps(3);
  endtask

  task automatic send_frame(input logic [3:0] nib, input bit par_flip,
                            input bit stop_bit, input bit clr_stop);
    logic par;
    bit   good;
    bit   perr;
    par  = (^nib) ^ par_flip;
    perr = PAR_EN && par_flip;
    good = stop_bit && !perr;
    send_bit(1'b0);
    for (int i = 3; i >= 0; i--) send_bit(nib[i]);
    if (PAR_EN) send_bit(par);
    ser_in   = stop_bit;
    bit_tick = 1'b1;
    if (!rnd_ctl) err_clr = clr_stop;
    step(1'b1, good, perr, !stop_bit, nib);
    bit_tick = 1'b0;
    ser_in   = 1'b1;
    if (!rnd_ctl) err_clr = 1'b0;
    idle_steps(3);
  endtask

  initial begin
    rst_n      = 1'b0;
    bit_tick   = 1'b0;
    ser_in     = 1'b1;
    pqrs_ready = 1'b1;
    err_clr    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    idle_steps(4);

    // Good frame 1011, ready held high
    send_frame(4'b1011, 1'b0, 1'b1, 1'b0);
    chk("good_cnt", frame_cnt, 8'd1);

    // Same nibble with the parity bit flipped
    send_frame(4'b1011, 1'b1, 1'b1, 1'b0);
    chk("perr_flag", {7'b0, parity_err}, 8'd1);
    chk("perr_cnt", frame_cnt, 8'd1);

    // Clear, then parity error with err_clr in the recording cycle
    err_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    err_clr = 1'b0;
    chk("clr_perr", {7'b0, parity_err}, 8'd0);
    send_frame(4'b1011, 1'b1, 1'b1, 1'b1);
    chk("set_beats_clr", {7'b0, parity_err}, 8'd1);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    err_clr = 1'b0;
    chk("clr_after", {7'b0, parity_err}, 8'd0);

    // Bad stop bit
    send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
    chk("ferr_flag", {7'b0, frame_err}, 8'd1);
    chk("ferr_valid", {7'b0, pqrs_valid}, 8'd0);

    // Overrun: downstream stalled across two good frames
    pqrs_ready = 1'b0;
    send_frame(4'b1011, 1'b0, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1, 1'b0);
    chk("ovr_pqrs", {4'b0, pqrs}, 8'h0b);
    chk("ovr_flag", {7'b0, overrun}, 8'd1);
    chk("ovr_cnt", frame_cnt, 8'd2);
    pqrs_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    pqrs_ready = 1'b0;
    chk("ovr_drain", {7'b0, pqrs_valid}, 8'd0);
    idle_steps(2);
    pqrs_ready = 1'b1;

    // Reset during the second data bit
    send_bit(1'b0);
    send_bit(1'b0);
    ser_in   = 1'b0;
    bit_tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge clk);
    bit_tick = 1'b0;
    ser_in   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle_steps(2);
    send_frame(4'b0001, 1'b0, 1'b1, 1'b0);
    chk("post_rst_pqrs", {4'b0, pqrs}, 8'h01);
    chk("post_rst_cnt", frame_cnt, 8'd1);

    // Randomized traffic, ready and err_clr varied every cycle
    rnd_ctl = 1'b1;
    for (int f = 0; f < 80; f++) begin
      int gap;
      gap = $urandom_range(0, 6);
      for (int g = 0; g < gap; g++) begin
        bit_tick = ($urandom_range(0, 3) == 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        bit_tick = 1'b0;
      end
      send_frame(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) != 0), 1'b0);
    end

    // Drive the delivered-nibble counter into saturation
    rnd_ctl    = 1'b0;
    pqrs_ready = 1'b1;
    err_clr    = 1'b0;
    for (int f = 0; f < 260; f++) send_frame(4'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0);
    chk("sat_cnt", frame_cnt, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
